seven_segment_tube_driver: RTL and testbench

Memory-mapped 8-digit seven-segment tube driver that consumes the tube-write strobe decoded by the CPU controller, latches the 32-bit display value and digit-enable mask written by the program, and time-multiplexes the digits onto the board's common-anode tube pins. It sits directly downstream of the controller's IO decode, in parallel with the LED and switch IO blocks, and is the only owner of the tube pins.

---
 rtl/seven_segment_tube_driver.sv | 110 +++++++++++
 tb/tb_seven_segment_tube_driver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_tube_driver.sv
// Purpose: 8-digit common-anode seven-segment driver with write-latched value and digit mask.
// Latency: a write lands at its edge and is visible on the pins one edge later; pins lag the scan index by one cycle.
// Backpressure: none, every write strobe is accepted in the cycle it is high.
//
// Ports:
//   iClock        system clock, rising edge
//   iReset        asynchronous active-high reset
//   iDoTubeWrite  write strobe from the IO decode
//   iTubeAddress  0 = value[15:0], 1 = value[31:16], 2 = digit mask, 3 = reserved
//   iWriteData    store data
//   oTubeSelect   digit enables, active low, bit i drives digit i
//   oTubeSegments segments {dp,g,f,e,d,c,b,a}, active low
module seven_segment_tube_driver #(
   parameter int CLOCK_DIV = 50000
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iDoTubeWrite,
   input  logic [1:0]  iTubeAddress,
   input  logic [15:0] iWriteData,
   output logic [7:0]  oTubeSelect,
   output logic [7:0]  oTubeSegments
);

   localparam int DIV_W = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);

   logic [31:0]      displayValue;
   logic [7:0]       digitMask;
   logic [DIV_W-1:0] divider;
   logic [2:0]       digitIndex;
   logic [3:0]       nibble;
   logic [7:0]       nextSelect;
   logic [7:0]       nextSegments;

   // Hex glyphs, active low, decimal point always off.
   function automatic logic [7:0] hexDecode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Program-visible registers; address 3 and idle cycles leave them alone.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         displayValue <= 32'h0;
         digitMask    <= 8'hFF;
      end else if (iDoTubeWrite) begin
         case (iTubeAddress)
            2'd0:    displayValue[15:0]  <= iWriteData;
            2'd1:    displayValue[31:16] <= iWriteData;
            2'd2:    digitMask           <= iWriteData[7:0];
            default: ;
         endcase
      end
   end

   // Free-running scan: each digit owns exactly CLOCK_DIV cycles, masked or not.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         divider    <= '0;
         digitIndex <= 3'd0;
      end else if (divider == DIV_LAST) begin
         divider    <= '0;
         digitIndex <= digitIndex + 3'd1;
      end else begin
         divider    <= divider + 1'b1;
      end
   end

   always_comb begin
      nibble = displayValue[{digitIndex, 2'b00} +: 4];
      if (digitMask[digitIndex]) begin
         nextSelect   = ~(8'h01 << digitIndex);
         nextSegments = hexDecode(nibble);
      end else begin
         nextSelect   = 8'hFF;
         nextSegments = 8'hFF;
      end
   end

   // Pins come straight from flops so select and segments switch together.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         oTubeSelect   <= 8'hFF;
         oTubeSegments <= 8'hFF;
      end else begin
         oTubeSelect   <= nextSelect;
         oTubeSegments <= nextSegments;
      end
   end

endmodule

// File: tb/tb_seven_segment_tube_driver.sv
module tb_seven_segment_tube_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        doW = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [15:0] wdat = 16'h0;
   logic [7:0]  sel;
   logic [7:0]  seg;

   int nVec = 0;
   int nErr = 0;

   logic [15:0] scb[$];

   // Reference state: what the program has written, and edges since reset.
   logic [31:0] mVal  = 32'h0;
   logic [7:0]  mMask = 8'hFF;
   int          t     = 0;

   logic [7:0] segTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seven_segment_tube_driver #(.CLOCK_DIV(DIV)) dut (
      .iClock(clk),
      .iReset(rst),
      .iDoTubeWrite(doW),
      .iTubeAddress(addr),
      .iWriteData(wdat),
      .oTubeSelect(sel),
      .oTubeSegments(seg)
   );

   always #5 clk = ~clk;

   // Model: the digit shown after edge t (t = 1 is the first edge after reset)
   // is ((t-1)/DIV) mod 8, using register contents from before the edge.
   always @(posedge clk) begin
      int d;
      if (rst) begin
         mVal  = 32'h0;
         mMask = 8'hFF;
         t     = 0;
         scb.push_back(16'hFFFF);
      end else begin
         t = t + 1;
         d = ((t - 1) / DIV) % 8;
         if (mMask[d])
            scb.push_back({~(8'h01 << d), segTab[mVal[4*d +: 4]]});
         else
            scb.push_back(16'hFFFF);
         if (doW) begin
            case (addr)
               2'd0: mVal[15:0]  = wdat;
               2'd1: mVal[31:16] = wdat;
               2'd2: mMask       = wdat[7:0];
               default: ;
            endcase
         end
      end
   end

   // Monitor: outputs are valid every cycle; compare away from the active edge.
   always @(negedge clk) begin
      logic [15:0] exp;
      if (scb.size() > 0) begin
         exp = scb.pop_front();
         nVec = nVec + 1;
         if ({sel, seg} !== exp) begin
            nErr = nErr + 1;
            $display("FAIL scan t=%0d: got sel/seg %h/%h, expected %h/%h",
                     t, sel, seg, exp[15:8], exp[7:0]);
         end
      end
   end

   task automatic writeReg(input logic [1:0] a, input logic [15:0] dat);
      @(negedge clk);
      doW  = 1'b1;
      addr = a;
      wdat = dat;
      @(negedge clk);
      doW  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkAsyncReset(input string tag);
      #2 rst = 1'b1;
      #1;
      nVec = nVec + 1;
      if (sel !== 8'hFF || seg !== 8'hFF) begin
         nErr = nErr + 1;
         $display("FAIL %s: got sel/seg %h/%h, expected FF/FF", tag, sel, seg);
      end
   endtask

   initial begin
      // Reset held, then idle scan of value 0 over more than one frame.
      idle(3);
      rst = 1'b0;
      idle(8 * DIV + 8);

      // Ascending digits 0..7.
      writeReg(2'd0, 16'h3210);
      doW = 1'b1; addr = 2'd1; wdat = 16'h7654;
      @(negedge clk);
      doW = 1'b0;
      idle(8 * DIV + 4);

      // Letters and high digits.
      writeReg(2'd1, 16'hFEDC);
      writeReg(2'd0, 16'hBA98);
      idle(8 * DIV + 4);

      // Mask only digits 0 and 2; upper data byte must be ignored.
      writeReg(2'd2, 16'hA505);
      idle(8 * DIV + 4);

      // Reserved address and non-strobed data must change nothing.
      writeReg(2'd3, 16'hFFFF);
      @(negedge clk);
      addr = 2'd0; wdat = 16'h1234;
      @(negedge clk);
      addr = 2'd2; wdat = 16'h00FF;
      idle(8 * DIV + 4);

      // Back-to-back writes to the same address: last one wins.
      writeReg(2'd2, 16'h00FF);
      doW = 1'b1; addr = 2'd0; wdat = 16'h1111;
      @(negedge clk);
      wdat = 16'hC0DE;
      @(negedge clk);
      doW = 1'b0;
      idle(8 * DIV + 4);

      // Random traffic, including strobe-low cycles with live address/data.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         doW  = ($urandom_range(0, 3) == 0);
         addr = 2'($urandom_range(0, 3));
         wdat = 16'($urandom);
      end
      @(negedge clk);
      doW = 1'b0;
      idle(8 * DIV + 4);

      // Reset mid-frame while digit 5 is lit and a write is in flight.
      checkAsyncReset("reset_plain");
      idle(2);
      rst = 1'b0;
      writeReg(2'd0, 16'h7777);
      writeReg(2'd1, 16'h7777);
      idle(5 * DIV - 2);
      doW = 1'b1; addr = 2'd0; wdat = 16'hABCD;
      checkAsyncReset("reset_digit5");
      idle(2);
      doW = 1'b0;
      rst = 1'b0;
      idle(8 * DIV + 8);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
